// File: rtl/vector_pkg.sv
// Shared types and default sizes for the sequential vector ALU slice.
// Optional saturation is controlled by VECTOR_ALU_SAT_EN (see vector_lane_alu).
package vector_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_VECTOR_LENGTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SRA = 3'b110,
        OP_MIN = 3'b111
    } vec_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/vector_lane_alu.sv
// Purely combinational single-lane signed ALU.
// With VECTOR_ALU_SAT_EN defined, ADD/SUB saturate; otherwise they wrap.
module vector_lane_alu
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [DATA_WIDTH-1:0]        add_y;
    logic [DATA_WIDTH-1:0]        sub_y;
    logic [DATA_WIDTH-1:0]        mul_y;
    logic [DATA_WIDTH-1:0]        sra_y;
    logic [DATA_WIDTH-1:0]        min_y;

    assign sa = signed'(a);
    assign sb = signed'(b);

`ifdef VECTOR_ALU_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH:0] sum_w;
    logic [DATA_WIDTH:0] diff_w;

    // One extra sign bit: overflow shows up as the top two bits disagreeing.
    assign sum_w  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign diff_w = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
            return v[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        return v[DATA_WIDTH-1:0];
    endfunction

    assign add_y = saturate(sum_w);
    assign sub_y = saturate(diff_w);
`else
    assign add_y = a + b;
    assign sub_y = a - b;
`endif

    // Low half of a product is identical for signed and unsigned operands.
    assign mul_y = a * b;
    assign sra_y = sa >>> b[3:0];
    assign min_y = (sa < sb) ? a : b;

    always_comb begin
        // NOTE: default assignment first so every path drives y and no latch is inferred.
        y = '0;
        case (op)
            OP_ADD: y = add_y;
            OP_SUB: y = sub_y;
            OP_MUL: y = mul_y;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SRA: y = sra_y;
            OP_MIN: y = min_y;
        endcase
    end

endmodule

// File: rtl/vector_alu_seq.sv
// Multi-cycle signed vector ALU: LANES_PER_CYCLE lanes per clock, start/busy/done handshake.
// Lanes are packed, lane i = a[i]; saturating ADD/SUB when VECTOR_ALU_SAT_EN is defined.
module vector_alu_seq
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int VECTOR_LENGTH   = DEFAULT_VECTOR_LENGTH,
    parameter int LANES_PER_CYCLE = 4
)(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [2:0]                                op,
    input  logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0]  a,
    input  logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0]  b,
    output logic                                      busy,
    output logic                                      done,
    output logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0]  result
);

    // LANES_PER_CYCLE must divide VECTOR_LENGTH evenly.
    localparam int N_CHUNKS = VECTOR_LENGTH / LANES_PER_CYCLE;
    localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int IW       = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]                                 state;
    logic [CW-1:0]                              chunk;
    logic [2:0]                                 op_q;
    logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0]   a_q;
    logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0]   b_q;
    logic [LANES_PER_CYCLE-1:0][IW-1:0]         lane_idx;
    logic [LANES_PER_CYCLE-1:0][DATA_WIDTH-1:0] lane_y;

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        assign lane_idx[g] = IW'(int'(chunk) * LANES_PER_CYCLE + g);

        vector_lane_alu #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .a  (a_q[lane_idx[g]]),
            .b  (b_q[lane_idx[g]]),
            .op (op_q),
            .y  (lane_y[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: result and captured operands are reset on purpose; a reset must leave all-zero lanes visible.
            state  <= S_IDLE;
            chunk  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        chunk <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < LANES_PER_CYCLE; i++)
                        result[lane_idx[i]] <= lane_y[i];
                    if (chunk == LAST_CHUNK)
                        state <= S_DONE;
                    else
                        chunk <= chunk + CW'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_vector_alu_seq.sv
// Self-checking bench for vector_alu_seq: randomized vectors against a lane-arithmetic model.
module tb_vector_alu_seq;

    localparam int DW  = 16;
    localparam int VL  = 16;
    localparam int LPC = 4;
    localparam int NCH = VL / LPC;
    localparam int LAT = NCH + 1;

    typedef logic [VL-1:0][DW-1:0] vec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op    = 3'd0;
    vec_t       a     = '0;
    vec_t       b     = '0;
    logic       busy;
    logic       done;
    vec_t       result;

    int n_pass  = 0;
    int n_total = 0;

    vector_alu_seq #(
        .DATA_WIDTH      (DW),
        .VECTOR_LENGTH   (VL),
        .LANES_PER_CYCLE (LPC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed integer arithmetic on each lane, truncated (or clamped) to DW bits.
    function automatic logic [DW-1:0] model_lane(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            3'd0: r = sx + sy;
            3'd1: r = sx - sy;
            3'd2: r = sx * sy;
            3'd3: r = sx & sy;
            3'd4: r = sx | sy;
            3'd5: r = sx ^ sy;
            3'd6: r = sx >>> int'(y[3:0]);
            default: r = (sx < sy) ? sx : sy;
        endcase
`ifdef VECTOR_ALU_SAT_EN
        if (o == 3'd0 || o == 3'd1) begin
            if (r > (1 << (DW-1)) - 1) r = (1 << (DW-1)) - 1;
            if (r < -(1 << (DW-1)))    r = -(1 << (DW-1));
        end
`endif
        return r[DW-1:0];
    endfunction

    function automatic vec_t model_vec(input logic [2:0] o, input vec_t x, input vec_t y);
        vec_t v;
        for (int i = 0; i < VL; i++) v[i] = model_lane(o, x[i], y[i]);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic [DW-1:0] corner [4];
        corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'h0000; corner[3] = 16'hFFFF;
        for (int i = 0; i < VL; i++)
            v[i] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : DW'($urandom);
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [DW-1:0] val);
        vec_t v;
        for (int i = 0; i < VL; i++) v[i] = val;
        return v;
    endfunction

    task automatic start_op(input logic [2:0] o, input vec_t va, input vec_t vb);
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the edge count (sampling edge = 1) at which done was first seen.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        if (busy) busy_cycles++;
    endtask

    task automatic run_op(input logic [2:0] o, input vec_t va, input vec_t vb, output vec_t res, output int edges);
        int bc;
        start_op(o, va, vb);
        wait_done(edges, bc);
        res = result;
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        a     = rand_vec();
        b     = rand_vec();
        tick();
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++;
        if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
        start = 1'b0;
        rst   = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_add_lanes();
        vec_t va, vb, exp;
        int edges, bc;
        for (int i = 0; i < VL; i++) begin
            va[i]  = DW'(i);
            vb[i]  = DW'(100);
            exp[i] = DW'(100 + i);
        end
        start_op(3'd0, va, vb);
        wait_done(edges, bc);
        n_total++;
        if (edges !== LAT || done !== 1'b1) $display("FAIL add_latency: got %0d edges expected %0d", edges, LAT); else n_pass++;
        n_total++;
        if (result !== exp) $display("FAIL add_result: got %h expected %h", result, exp); else n_pass++;
        n_total++;
        if (bc !== LAT) $display("FAIL add_busy_cycles: got %0d expected %0d", bc, LAT); else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL add_after_done: got done=%b busy=%b expected 0 0", done, busy); else n_pass++;
    endtask

    task automatic test_overflow();
        vec_t res, exp;
        int edges;
        run_op(3'd0, fill_vec(16'h7FFF), fill_vec(16'h0001), res, edges);
`ifdef VECTOR_ALU_SAT_EN
        exp = fill_vec(16'h7FFF);
`else
        exp = fill_vec(16'h8000);
`endif
        n_total++;
        if (res !== exp) $display("FAIL add_overflow: got %h expected %h", res, exp); else n_pass++;
        run_op(3'd1, fill_vec(16'h8000), fill_vec(16'h0001), res, edges);
`ifdef VECTOR_ALU_SAT_EN
        exp = fill_vec(16'h8000);
`else
        exp = fill_vec(16'h7FFF);
`endif
        n_total++;
        if (res !== exp) $display("FAIL sub_underflow: got %h expected %h", res, exp); else n_pass++;
    endtask

    task automatic test_mul_sra();
        vec_t res, exp;
        int edges;
        run_op(3'd2, fill_vec(16'hFFFD), fill_vec(16'h0007), res, edges);
        exp = fill_vec(16'hFFEB);
        n_total++;
        if (res !== exp) $display("FAIL mul_neg: got %h expected %h", res, exp); else n_pass++;
        run_op(3'd6, fill_vec(16'h8000), fill_vec(16'h00F4), res, edges);
        exp = fill_vec(16'hF800);
        n_total++;
        if (res !== exp) $display("FAIL sra_shift4: got %h expected %h", res, exp); else n_pass++;
    endtask

    task automatic test_random();
        vec_t va, vb, res, exp;
        logic [2:0] o;
        int edges;
        for (int k = 0; k < 16; k++) begin
            o   = 3'(k % 8);
            va  = rand_vec();
            vb  = rand_vec();
            exp = model_vec(o, va, vb);
            run_op(o, va, vb, res, edges);
            n_total++;
            if (res !== exp || edges !== LAT)
                $display("FAIL random_op%0d: got %h (%0d edges) expected %h (%0d edges)", o, res, edges, exp, LAT);
            else
                n_pass++;
        end
    endtask

    task automatic test_ignored_start();
        vec_t va, vb, exp, res;
        int dones;
        va  = rand_vec();
        vb  = rand_vec();
        exp = model_vec(3'd0, va, vb);
        res = '0;
        dones = 0;
        start_op(3'd0, va, vb);
        tick();
        op    = 3'd1;
        a     = ~va;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = rand_vec();
        b     = rand_vec();
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                dones++;
                res = result;
            end
            tick();
        end
        n_total++;
        if (dones !== 1) $display("FAIL ignored_start_dones: got %0d expected 1", dones); else n_pass++;
        n_total++;
        if (res !== exp) $display("FAIL ignored_start_result: got %h expected %h", res, exp); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL ignored_start_idle: got busy=%b expected 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        vec_t exp;
        int done_edges[$];
        exp   = fill_vec(16'hFFFB);
        op    = 3'd7;
        a     = fill_vec(16'h0005);
        b     = fill_vec(16'hFFFB);
        start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (done) begin
                done_edges.push_back(e);
                n_total++;
                if (result !== exp) $display("FAIL b2b_result_edge%0d: got %h expected %h", e, result, exp); else n_pass++;
            end
        end
        start = 1'b0;
        n_total++;
        if (done_edges.size() !== 5) $display("FAIL b2b_done_count: got %0d expected 5", done_edges.size()); else n_pass++;
        for (int i = 1; i < done_edges.size(); i++) begin
            n_total++;
            if (done_edges[i] - done_edges[i-1] !== NCH + 2)
                $display("FAIL b2b_interval%0d: got %0d expected %0d", i, done_edges[i] - done_edges[i-1], NCH + 2);
            else
                n_pass++;
        end
        for (int k = 0; k < 10 && busy; k++) tick();
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        start_op(3'd0, rand_vec(), rand_vec());
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++;
        if (result !== '0) $display("FAIL midrun_reset_result: got %h expected 0", result); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (done) dones++;
            tick();
        end
        n_total++;
        if (dones !== 0) $display("FAIL midrun_reset_done: got %0d pulses expected 0", dones); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_lanes();
        test_overflow();
        test_mul_sra();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
